// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared constants and types for the data-memory / MMIO block:
//                MMIO register offsets, TCTRL bit positions, default MMIO base.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // MMIO register offsets (maddr[7:0])
    localparam logic [7:0] OFS_LED   = 8'h00;
    localparam logic [7:0] OFS_TCNT  = 8'h04;
    localparam logic [7:0] OFS_TCMP  = 8'h08;
    localparam logic [7:0] OFS_TCTRL = 8'h0C;
    localparam logic [7:0] OFS_CYCLE = 8'h10;

    // TCTRL bit positions
    localparam int TCTRL_EN         = 0;
    localparam int TCTRL_AUTORELOAD = 1;
    localparam int TCTRL_MATCH      = 2;
    localparam int TCTRL_IRQEN      = 3;

    // Default base address of the MMIO window (only [31:16] is decoded)
    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_0000;

    // Packed view of TCTRL[3:0]; member order matches the bit positions above
    typedef struct packed {
        logic irqen;
        logic match;
        logic autoreload;
        logic en;
    } tctrl_t;

    // Zero-extend the control bits to a full bus word
    function automatic logic [31:0] tctrl_word(tctrl_t t);
        return {28'h0, t};
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_mmio_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_mmio_if
//  Description : Memory-stage request / read-data bundle between the CPU
//                (master) and the data-memory block (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface dmem_mmio_if;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic        DM_CS_M;
    logic        DM_R_M;
    logic        DM_W_M;
    logic [31:0] mr_data_M;

    modport master (
        output maddr, mwdata, DM_CS_M, DM_R_M, DM_W_M,
        input  mr_data_M
    );

    modport slave (
        input  maddr, mwdata, DM_CS_M, DM_R_M, DM_W_M,
        output mr_data_M
    );
endinterface
`default_nettype wire

// File: rtl/mmio_timer.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_timer
//  Description : Programmable timer (TCNT / TCMP / TCTRL) with compare match,
//                one-shot or auto-reload mode, W1C match flag and irq output.
//                Register write port is pre-qualified by the MMIO decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module mmio_timer
    import dmem_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        wr_en,
    input  wire logic [7:0]  ofs,
    input  wire logic [31:0] wdata,
    output logic      [31:0] rdata,
    output logic             irq
);

    logic [31:0] tcnt_q,  tcnt_d;
    logic [31:0] tcmp_q,  tcmp_d;
    tctrl_t      tctrl_q, tctrl_d;

    logic wr_tcnt;
    logic wr_tcmp;
    logic wr_tctrl;
    logic match_set;

    // Next-state: hardware count/match first, software writes layered on top
    always_comb begin
        wr_tcnt   = wr_en && (ofs == OFS_TCNT);
        wr_tcmp   = wr_en && (ofs == OFS_TCMP);
        wr_tctrl  = wr_en && (ofs == OFS_TCTRL);
        tcnt_d    = tcnt_q;
        tcmp_d    = tcmp_q;
        tctrl_d   = tctrl_q;
        match_set = 1'b0;

        // A TCNT write suppresses the whole count/match step for this cycle
        if (tctrl_q.en && !wr_tcnt) begin
            if (tcnt_q == tcmp_q) begin
                match_set = 1'b1;
                if (tctrl_q.autoreload) begin
                    tcnt_d = '0;
                end else begin
                    tctrl_d.en = 1'b0;
                end
            end else begin
                tcnt_d = tcnt_q + 32'd1;
            end
        end

        if (wr_tcnt) begin
            tcnt_d = wdata;
        end
        if (wr_tcmp) begin
            tcmp_d = wdata;
        end
        // Software control write overrides a same-cycle hardware EN clear
        if (wr_tctrl) begin
            tctrl_d.en         = wdata[TCTRL_EN];
            tctrl_d.autoreload = wdata[TCTRL_AUTORELOAD];
            tctrl_d.irqen      = wdata[TCTRL_IRQEN];
            if (wdata[TCTRL_MATCH]) begin
                tctrl_d.match = 1'b0;
            end
        end
        // A new match beats a same-cycle write-1-to-clear
        if (match_set) begin
            tctrl_d.match = 1'b1;
        end
    end

    // Timer state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt_q  <= '0;
            tcmp_q  <= 32'hFFFF_FFFF;
            tctrl_q <= '0;
        end else begin
            tcnt_q  <= tcnt_d;
            tcmp_q  <= tcmp_d;
            tctrl_q <= tctrl_d;
        end
    end

    // Register read mux; offsets outside the timer read as zero
    always_comb begin
        rdata = '0;
        case (ofs)
            OFS_TCNT:  rdata = tcnt_q;
            OFS_TCMP:  rdata = tcmp_q;
            OFS_TCTRL: rdata = tctrl_word(tctrl_q);
            default:   rdata = '0;
        endcase
    end

    assign irq = tctrl_q.match & tctrl_q.irqen;

endmodule
`default_nettype wire

// File: rtl/dmem_mmio.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_mmio
//  Description : CPU data memory: word-addressed RAM plus an MMIO window
//                holding LED, cycle counter and (optionally) a timer.
//                Reads are combinational, writes land on the rising edge.
//                Optional feature macro: DMEM_MMIO_TIMER_EN (timer + irq).
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_mmio
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = MMIO_BASE_DEFAULT
)(
    input  wire logic        clk,
    input  wire logic        reset,
    dmem_mmio_if.slave       bus,
    output logic      [15:0] led,
    output logic             timer_irq
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]   mem_q [DEPTH_WORDS];
    logic [15:0]   led_q,   led_d;
    logic [31:0]   cycle_q, cycle_d;

    logic          mmio_hit;
    logic          bus_wr;
    logic          bus_rd;
    logic          mmio_wr;
    logic          ram_wr;
    logic [7:0]    ofs;
    logic [AW-1:0] ram_idx;
    logic [31:0]   tmr_rdata;
    logic          tmr_irq;

    // Byte-lane bits and address bits above the RAM index are don't-care
    logic unused_bus;
    assign unused_bus = ^{bus.maddr, bus.mwdata};

    // Address decode and access qualification
    always_comb begin
        mmio_hit = (bus.maddr[31:16] == MMIO_BASE[31:16]);
        bus_wr   = bus.DM_CS_M && bus.DM_W_M;
        bus_rd   = bus.DM_CS_M && bus.DM_R_M;
        mmio_wr  = bus_wr && mmio_hit;
        ram_wr   = bus_wr && !mmio_hit;
        ofs      = bus.maddr[7:0];
        ram_idx  = bus.maddr[AW+1:2];
    end

`ifdef DMEM_MMIO_TIMER_EN
    mmio_timer u_timer (
        .clk   (clk),
        .reset (reset),
        .wr_en (mmio_wr),
        .ofs   (ofs),
        .wdata (bus.mwdata),
        .rdata (tmr_rdata),
        .irq   (tmr_irq)
    );
`else
    assign tmr_rdata = '0;
    assign tmr_irq   = 1'b0;
`endif

    // RAM write port; contents are not reset and writes are dropped in reset
    always_ff @(posedge clk) begin
        if (!reset && ram_wr) begin
            mem_q[ram_idx] <= bus.mwdata;
        end
    end

    // LED register next-state and free-running cycle counter
    always_comb begin
        led_d   = led_q;
        cycle_d = cycle_q + 32'd1;
        if (mmio_wr && (ofs == OFS_LED)) begin
            led_d = bus.mwdata[15:0];
        end
    end

    // LED and cycle counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            led_q   <= '0;
            cycle_q <= '0;
        end else begin
            led_q   <= led_d;
            cycle_q <= cycle_d;
        end
    end

    // Combinational read data; old RAM value on a same-cycle write
    always_comb begin
        bus.mr_data_M = '0;
        if (bus_rd) begin
            if (mmio_hit) begin
                case (ofs)
                    OFS_LED:   bus.mr_data_M = {16'h0, led_q};
                    OFS_CYCLE: bus.mr_data_M = cycle_q;
                    default:   bus.mr_data_M = tmr_rdata;
                endcase
            end else begin
                bus.mr_data_M = mem_q[ram_idx];
            end
        end
    end

    assign led       = led_q;
    assign timer_irq = tmr_irq;

endmodule
`default_nettype wire

// File: tb/tb_dmem_mmio.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_mmio
//  Description : Self-checking bench for dmem_mmio. Expected read data is
//                queued when a read is driven and compared when sampled.
//                Timer scenarios are built when DMEM_MMIO_TIMER_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_mmio;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] MB    = 32'hFFFF_0000;
    localparam logic [31:0] A_LED   = MB + 32'h00;
    localparam logic [31:0] A_TCNT  = MB + 32'h04;
    localparam logic [31:0] A_TCMP  = MB + 32'h08;
    localparam logic [31:0] A_TCTRL = MB + 32'h0C;
    localparam logic [31:0] A_CYCLE = MB + 32'h10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] led;
    logic        timer_irq;

    dmem_mmio_if bus ();

    dmem_mmio #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(MB)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .led       (led),
        .timer_irq (timer_irq)
    );

    always #5 clk = ~clk;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_cycle = 32'd0;

    // Reference cycle counter
    always @(posedge clk) begin
        if (reset) model_cycle <= 32'd0;
        else       model_cycle <= model_cycle + 32'd1;
    end

    task automatic next();
        @(posedge clk); #1;
    endtask

    task automatic bus_idle();
        bus.DM_CS_M = 1'b0; bus.DM_R_M = 1'b0; bus.DM_W_M = 1'b0;
        bus.maddr = 32'h0;  bus.mwdata = 32'h0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus.DM_CS_M = 1'b1; bus.DM_R_M = 1'b0; bus.DM_W_M = 1'b1;
        bus.maddr = a; bus.mwdata = d;
        next();
        bus_idle();
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] e);
        bus.DM_CS_M = 1'b1; bus.DM_R_M = 1'b1; bus.DM_W_M = 1'b0;
        bus.maddr = a;
        exp_q.push_back(e);
    endtask

    task automatic sample(output logic [31:0] got, output logic [31:0] e);
        @(negedge clk);
        got = bus.mr_data_M;
        e   = exp_q.pop_front();
    endtask

    task automatic test_reset();
        logic [31:0] got, e;
        bus_idle();
        reset = 1'b1;
        repeat (3) next();
        n_cmp++;
        if (led !== 16'h0) begin n_fail++; $display("FAIL reset_led: got %h expected %h", led, 16'h0); end
        n_cmp++;
        if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", timer_irq); end
        bus_read(A_CYCLE, 32'h0);
        sample(got, e); n_cmp++;
        if (got !== e) begin n_fail++; $display("FAIL reset_cycle: got %h expected %h", got, e); end
`ifdef DMEM_MMIO_TIMER_EN
        next();
        bus_read(A_TCMP, 32'hFFFF_FFFF);
        sample(got, e); n_cmp++;
        if (got !== e) begin n_fail++; $display("FAIL reset_tcmp: got %h expected %h", got, e); end
`endif
        next();
        reset = 1'b0;
        bus_idle();
    endtask

    task automatic test_ram();
        logic [31:0] got, e;
        logic [31:0] addrs [5] = '{32'h40, 32'h40 + 4*DEPTH, 32'hFFFE_0040, 32'h8000_0041, 32'h44};
        logic [31:0] exps  [5] = '{32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0BADF00D};
        bus_write(32'h40, 32'hDEADBEEF);
        bus_write(32'h44, 32'h0BADF00D);
        for (int i = 0; i < 5; i++) begin
            bus_read(addrs[i], exps[i]);
            sample(got, e); n_cmp++;
            if (got !== e) begin n_fail++; $display("FAIL ram_rd%0d: got %h expected %h", i, got, e); end
            next();
        end
        // Read without DM_R_M, then without chip select: both return zero
        bus_read(32'h40, 32'h0); bus.DM_R_M = 1'b0;
        sample(got, e); n_cmp++;
        if (got !== e) begin n_fail++; $display("FAIL ram_no_re: got %h expected %h", got, e); end
        next();
        bus_read(32'h40, 32'h0); bus.DM_CS_M = 1'b0;
        sample(got, e); n_cmp++;
        if (got !== e) begin n_fail++; $display("FAIL ram_no_cs: got %h expected %h", got, e); end
        // Write without chip select is ignored
        bus.DM_CS_M = 1'b0; bus.DM_R_M = 1'b0; bus.DM_W_M = 1'b1;
        bus.maddr = 32'h44; bus.mwdata = 32'h0;
        next();
        bus_read(32'h44, 32'h0BADF00D);
        sample(got, e); n_cmp++;
        if (got !== e) begin n_fail++; $display("FAIL ram_cs_wr: got %h expected %h", got, e); end
        next();
        bus_idle();
    endtask

    task automatic test_same_cycle();
        logic [31:0] got, e;
        bus_write(32'h80, 32'h1);
        bus_read(32'h80, 32'h1);
        bus.DM_W_M = 1'b1; bus.mwdata = 32'h2;
        sample(got, e); n_cmp++;
        if (got !== e) begin n_fail++; $display("FAIL rw_same_old: got %h expected %h", got, e); end
        next();
        bus_read(32'h80, 32'h2);
        sample(got, e); n_cmp++;
        if (got !== e) begin n_fail++; $display("FAIL rw_same_new: got %h expected %h", got, e); end
        next();
        bus_idle();
    endtask

    task automatic test_led_cycle();
        logic [31:0] got, e;
        bus_write(A_LED, 32'h1234ABCD);
        n_cmp++;
        if (led !== 16'hABCD) begin n_fail++; $display("FAIL led_port: got %h expected %h", led, 16'hABCD); end
        bus_write(32'h0000_0000, 32'h0000FFFF);   // RAM word 0, not the LED
        bus_write(MB + 32'h20, 32'hFFFF_FFFF);    // unmapped offset
        bus_write(A_CYCLE, 32'h0);                // read-only
        bus_read(A_LED, 32'h0000ABCD);
        sample(got, e); n_cmp++;
        if (got !== e) begin n_fail++; $display("FAIL led_read: got %h expected %h", got, e); end
        next();
        bus_read(MB + 32'h0100, 32'h0000ABCD);    // only maddr[7:0] selects
        sample(got, e); n_cmp++;
        if (got !== e) begin n_fail++; $display("FAIL led_alias: got %h expected %h", got, e); end
        next();
        bus_read(MB + 32'h20, 32'h0);
        sample(got, e); n_cmp++;
        if (got !== e) begin n_fail++; $display("FAIL mmio_unmapped: got %h expected %h", got, e); end
        for (int i = 0; i < 2; i++) begin
            next();
            bus_read(A_CYCLE, model_cycle);
            sample(got, e); n_cmp++;
            if (got !== e) begin n_fail++; $display("FAIL cycle_%0d: got %h expected %h", i, got, e); end
        end
        next();
        bus_idle();
    endtask

`ifdef DMEM_MMIO_TIMER_EN
    task automatic test_timer_oneshot();
        logic [31:0] got, e;
        bus_write(A_TCMP, 32'd3);
        bus_write(A_TCTRL, 32'h9);                // edge 0
        repeat (3) next();
        bus_read(A_TCNT, 32'd3);
        sample(got, e); n_cmp++;
        if (got !== e || timer_irq !== 1'b0) begin
            n_fail++; $display("FAIL os_edge3: got %h/%b expected %h/0", got, timer_irq, e);
        end
        next();                                   // after edge 4
        bus_read(A_TCTRL, 32'hC);
        sample(got, e); n_cmp++;
        if (got !== e) begin n_fail++; $display("FAIL os_tctrl: got %h expected %h", got, e); end
        n_cmp++;
        if (timer_irq !== 1'b1) begin n_fail++; $display("FAIL os_irq: got %b expected 1", timer_irq); end
        next();
        bus_read(A_TCNT, 32'd3);
        sample(got, e); n_cmp++;
        if (got !== e) begin n_fail++; $display("FAIL os_hold: got %h expected %h", got, e); end
        bus_write(A_TCTRL, 32'h4);
        n_cmp++;
        if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL os_clr_irq: got %b expected 0", timer_irq); end
        bus_read(A_TCTRL, 32'h0);
        sample(got, e); n_cmp++;
        if (got !== e) begin n_fail++; $display("FAIL os_clr_tctrl: got %h expected %h", got, e); end
        next();
        bus_idle();
    endtask

    task automatic test_timer_autoreload();
        logic [31:0] got, e;
        bus_write(A_TCNT, 32'd0);
        bus_write(A_TCMP, 32'd1);
        bus_write(A_TCTRL, 32'h3);                // edge 0
        for (int i = 0; i < 4; i++) begin
            if (i > 0) next();
            bus_read(A_TCNT, 32'(i % 2));
            sample(got, e); n_cmp++;
            if (got !== e) begin n_fail++; $display("FAIL ar_tcnt%0d: got %h expected %h", i, got, e); end
        end
        // TCNT==TCMP now, so MATCH sets at the same edge as this W1C
        bus_write(A_TCTRL, 32'h7);
        bus_read(A_TCTRL, 32'h7);
        sample(got, e); n_cmp++;
        if (got !== e) begin n_fail++; $display("FAIL ar_w1c_collide: got %h expected %h", got, e); end
        bus_write(A_TCTRL, 32'h7);                // no match this edge
        bus_read(A_TCTRL, 32'h3);
        sample(got, e); n_cmp++;
        if (got !== e) begin n_fail++; $display("FAIL ar_w1c_clear: got %h expected %h", got, e); end
        next();
        bus_idle();
    endtask
`else
    task automatic test_timer_absent();
        logic [31:0] got, e;
        logic [31:0] addrs [3] = '{A_TCNT, A_TCMP, A_TCTRL};
        bus_write(A_TCNT, 32'd5);
        bus_write(A_TCMP, 32'd0);
        bus_write(A_TCTRL, 32'hF);
        for (int i = 0; i < 3; i++) begin
            bus_read(addrs[i], 32'h0);
            sample(got, e); n_cmp++;
            if (got !== e) begin n_fail++; $display("FAIL notimer_rd%0d: got %h expected %h", i, got, e); end
            next();
        end
        n_cmp++;
        if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL notimer_irq: got %b expected 0", timer_irq); end
        bus_idle();
    endtask
`endif

    task automatic test_reset_mid_count();
        logic [31:0] got, e;
        bus_write(A_LED, 32'h5A5A);
`ifdef DMEM_MMIO_TIMER_EN
        bus_write(A_TCMP, 32'd100);
        bus_write(A_TCTRL, 32'h1);
        bus_write(A_TCNT, 32'd5);
        bus_read(A_TCNT, 32'd5);
        sample(got, e); n_cmp++;
        if (got !== e) begin n_fail++; $display("FAIL rst_pre_tcnt: got %h expected %h", got, e); end
`endif
        // One reset cycle with a RAM write that must be discarded
        reset = 1'b1;
        bus.DM_CS_M = 1'b1; bus.DM_R_M = 1'b0; bus.DM_W_M = 1'b1;
        bus.maddr = 32'h40; bus.mwdata = 32'h1111_1111;
        next();
        reset = 1'b0;
        bus_idle();
        bus_read(A_CYCLE, 32'h0);
        sample(got, e); n_cmp++;
        if (got !== e) begin n_fail++; $display("FAIL rst_cycle: got %h expected %h", got, e); end
        n_cmp++;
        if (led !== 16'h0) begin n_fail++; $display("FAIL rst_led: got %h expected %h", led, 16'h0); end
        next();
        bus_read(32'h40, 32'hDEADBEEF);
        sample(got, e); n_cmp++;
        if (got !== e) begin n_fail++; $display("FAIL rst_ram: got %h expected %h", got, e); end
`ifdef DMEM_MMIO_TIMER_EN
        next();
        bus_read(A_TCNT, 32'h0);
        sample(got, e); n_cmp++;
        if (got !== e) begin n_fail++; $display("FAIL rst_tcnt: got %h expected %h", got, e); end
        next();
        bus_read(A_TCTRL, 32'h0);
        sample(got, e); n_cmp++;
        if (got !== e) begin n_fail++; $display("FAIL rst_tctrl: got %h expected %h", got, e); end
`endif
        next();
        bus_idle();
    endtask

    initial begin
        bus_idle();
        test_reset();
        test_ram();
        test_same_cycle();
        test_led_cycle();
`ifdef DMEM_MMIO_TIMER_EN
        test_timer_oneshot();
        test_timer_autoreload();
`else
        test_timer_absent();
`endif
        test_reset_mid_count();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
